// File: rtl/conv_channel_scheduler_if.sv
// ---------------------------------------------------------------------------
// conv_channel_scheduler_if
//   Bundles the channel-side inputs and the serialized output stream of the
//   convolution channel scheduler.
//
//   Signals:
//     sched_en    scheduler may pop channel FIFOs (low freezes sequencing)
//     valid_in    per-channel push strobes
//     pxl_in      channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
//     out_ready   downstream accepts pxl_out this cycle
//     pxl_out     serialized pixel word
//     valid_out   pxl_out valid
//     ch_out      channel index of pxl_out
//     last_ch     high with valid_out for channel NUM_CH-1
//     frame_done  one-cycle pulse after the final word of a frame is accepted
//     overflow    sticky: a push hit a full FIFO
//     stall_cnt   stall performance counter (zero when not compiled in)
//
//   Modports: master = producer/consumer side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface conv_channel_scheduler_if #(
    parameter int NUM_CH     = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int CW = $clog2(NUM_CH);

    logic                         sched_en;
    logic [NUM_CH-1:0]            valid_in;
    logic [NUM_CH*DATA_WIDTH-1:0] pxl_in;
    logic                         out_ready;
    logic [DATA_WIDTH-1:0]        pxl_out;
    logic                         valid_out;
    logic [CW-1:0]                ch_out;
    logic                         last_ch;
    logic                         frame_done;
    logic                         overflow;
    logic [31:0]                  stall_cnt;

    modport master (
        output sched_en, valid_in, pxl_in, out_ready,
        input  pxl_out, valid_out, ch_out, last_ch, frame_done, overflow, stall_cnt
    );

    modport slave (
        input  sched_en, valid_in, pxl_in, out_ready,
        output pxl_out, valid_out, ch_out, last_ch, frame_done, overflow, stall_cnt
    );
endinterface

// File: rtl/conv_channel_scheduler.sv
// ---------------------------------------------------------------------------
// conv_channel_scheduler
//   Buffers the outputs of NUM_CH parallel convolution channels in small
//   per-channel FIFOs and re-emits them as one channel-interleaved stream
//   (channel 0..NUM_CH-1 of pixel 0, then pixel 1, ...). Counts pixels per
//   frame, pulses frame_done at the end of a frame and flags FIFO overflow.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     bus    conv_channel_scheduler_if.slave (see interface header)
//
//   Optional feature:
//     SCHED_PERF_CNT_EN  when defined, stall_cnt counts (saturating) the
//                        cycles in RUN where the output register is free but
//                        the current channel FIFO is empty; otherwise 0.
// ---------------------------------------------------------------------------
module conv_channel_scheduler #(
    parameter int NUM_CH        = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4,
    parameter int PIX_PER_FRAME = 21609
) (
    input logic                     clk,
    input logic                     reset,
    conv_channel_scheduler_if.slave bus
);
    localparam int CW  = $clog2(NUM_CH);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int PCW = $clog2(PIX_PER_FRAME + 1);

    typedef enum logic [0:0] {IDLE, RUN} state_t;

    state_t                state_q, state_d;

    logic [DATA_WIDTH-1:0] mem_q    [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q [NUM_CH];
    logic [PW-1:0]         rd_ptr_q [NUM_CH];
    logic [NUM_CH-1:0]     empty, full, push, pop;

    logic [CW-1:0]         ch_ptr_q, ch_ptr_d;
    logic [PCW-1:0]        pix_cnt_q, pix_cnt_d;
    logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
    logic [CW-1:0]         ch_out_q, ch_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  last_ch_q, last_ch_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;

    logic                  out_free;
    logic                  pop_en;
    logic [DATA_WIDTH-1:0] head;

    // FIFO status: pointers carry one extra wrap bit to tell full from empty.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
            full[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                       (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
        end
    end

    assign out_free = !valid_out_q || bus.out_ready;
    assign pop_en   = (state_q == RUN) && bus.sched_en && out_free && !empty[ch_ptr_q];
    assign pop      = pop_en ? (NUM_CH'(1) << ch_ptr_q) : '0;
    // A full FIFO still takes a push when it is being popped in the same cycle.
    assign push     = bus.valid_in & (~full | pop);
    assign head     = mem_q[ch_ptr_q][rd_ptr_q[ch_ptr_q][AW-1:0]];

    // Storage is data only; it needs no reset because the pointers gate it.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k][AW-1:0]] <= bus.pxl_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PW'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ch_ptr_q     <= '0;
            pix_cnt_q    <= '0;
            pxl_out_q    <= '0;
            ch_out_q     <= '0;
            valid_out_q  <= 1'b0;
            last_ch_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_ptr_q     <= ch_ptr_d;
            pix_cnt_q    <= pix_cnt_d;
            pxl_out_q    <= pxl_out_d;
            ch_out_q     <= ch_out_d;
            valid_out_q  <= valid_out_d;
            last_ch_q    <= last_ch_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_ptr_d     = ch_ptr_q;
        pix_cnt_d    = pix_cnt_q;
        pxl_out_d    = pxl_out_q;
        ch_out_d     = ch_out_q;
        valid_out_d  = valid_out_q;
        last_ch_d    = last_ch_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (|(bus.valid_in & full & ~pop));

        // A pixel position completes when its last channel word is accepted.
        if (valid_out_q && bus.out_ready && last_ch_q) begin
            if (pix_cnt_q == PCW'(PIX_PER_FRAME - 1)) begin
                frame_done_d = 1'b1;
                pix_cnt_d    = '0;
            end else begin
                pix_cnt_d    = pix_cnt_q + PCW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (out_free) begin
                    valid_out_d = 1'b0;
                    last_ch_d   = 1'b0;
                end
                if (bus.sched_en) state_d = RUN;
            end
            RUN: begin
                if (!bus.sched_en) begin
                    // Leave only once the word on the output has been taken.
                    if (out_free) begin
                        valid_out_d = 1'b0;
                        last_ch_d   = 1'b0;
                        state_d     = IDLE;
                    end
                end else if (out_free) begin
                    if (pop_en) begin
                        pxl_out_d   = head;
                        ch_out_d    = ch_ptr_q;
                        last_ch_d   = (ch_ptr_q == CW'(NUM_CH - 1));
                        valid_out_d = 1'b1;
                        ch_ptr_d    = ch_ptr_q + CW'(1);
                    end else begin
                        // Strict order: wait on the current channel, never skip.
                        valid_out_d = 1'b0;
                        last_ch_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SCHED_PERF_CNT_EN
    logic        stall;
    logic [31:0] stall_cnt_q;

    assign stall = (state_q == RUN) && bus.sched_en && out_free && empty[ch_ptr_q];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

    assign bus.pxl_out    = pxl_out_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.ch_out     = ch_out_q;
    assign bus.last_ch    = last_ch_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: doc/conv_channel_scheduler.md
Name: conv_channel_scheduler

Overview:
- Sits between a 32-channel parallel convolution stage and the single-stream pixel consumer of the next layer.
- Buffers each channel's output in a small per-channel FIFO. Channel valids may be skewed or simultaneous.
- Emits one channel-interleaved stream: channel 0..NUM_CH-1 for pixel 0, then pixel 1, and so on.
- Counts pixels per frame, signals frame completion, and flags buffer overflow.

Parameters:
- NUM_CH, 32, number of parallel channel inputs (power of 2, ≥2).
- DATA_WIDTH, 32, pixel word width.
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2).
- PIX_PER_FRAME, 21609, output pixel positions per frame (147×147).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sched_en  in  1  high = scheduler may pop FIFOs; low = freeze sequencing (FIFOs still accept pushes).
- valid_in  in  NUM_CH  per-channel push strobe.
- pxl_in  in  NUM_CH*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_ready  in  1  downstream accepts pxl_out this cycle.
- pxl_out  out  DATA_WIDTH  serialized pixel.
- valid_out  out  1  pxl_out valid.
- ch_out  out  log2(NUM_CH)  channel index of pxl_out.
- last_ch  out  1  high with valid_out when ch_out = NUM_CH-1.
- frame_done  out  1  one-cycle pulse on acceptance of the final word of a frame.
- overflow  out  1  sticky; push to a full FIFO occurred.
- stall_cnt  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): all FIFOs empty; ch_ptr=0; pix_cnt=0; state=IDLE.
  - Outputs after reset: pxl_out=0, valid_out=0, ch_out=0, last_ch=0, frame_done=0, overflow=0, stall_cnt=0.
- Reset asserted mid-frame discards all buffered and in-flight data. No partial frame_done is produced.
- FIFO push: valid_in[k]=1 at edge E writes pxl_in slice k into FIFO k.
  - If FIFO k is full and not popped at E: the word is dropped and overflow is set (cleared only by reset).
  - Full with a simultaneous pop at E: the push is accepted, no overflow.
- Output register acceptance: the output register is "free" when valid_out=0 or out_ready=1.
- FSM states:
  - IDLE: go to RUN when sched_en=1.
  - RUN: at each edge with sched_en=1, free output register and FIFO[ch_ptr] non-empty:
    - pop FIFO[ch_ptr];
    - load pxl_out, ch_out=ch_ptr, last_ch=(ch_ptr==NUM_CH-1), valid_out=1;
    - advance ch_ptr modulo NUM_CH.
  - RUN, output register free but FIFO[ch_ptr] empty: valid_out goes to 0. This is a stall cycle.
  - RUN, output register not free: everything holds (pxl_out, ch_out, valid_out stable).
  - RUN with sched_en=0: return to IDLE after the current output word is accepted. ch_ptr and pix_cnt are retained.
- Strict channel order: never skip to a later channel even if its FIFO holds data.
- Latency: a word pushed at edge E into an empty FIFO, when it is the current channel and the output register is free, appears on pxl_out after edge E+1.
  - Throughput is 1 word/cycle when data is available.
- Pixel counting:
  - On acceptance (valid_out & out_ready) of a word with last_ch=1, pix_cnt increments.
  - At pix_cnt = PIX_PER_FRAME-1, that acceptance instead pulses frame_done for the next cycle and wraps pix_cnt to 0.
- Simultaneous push and pop on the same FIFO in one cycle: both take effect; occupancy is unchanged.

Optional Feature:
- Macro: SCHED_PERF_CNT_EN.
- Defined: stall_cnt increments (saturating at 2^32-1) every cycle in RUN where the output register is free and FIFO[ch_ptr] is empty.
- Undefined: counter logic is omitted and stall_cnt is tied to 0.

Test Plan:
- All 32 valid_in high for 1 cycle with pxl_in[k]=k+100, out_ready=1, sched_en=1 -> 32 consecutive valid_out words with values 100..131 and ch_out 0..31; last_ch only on 131; no overflow.
- Skew: channel 0 valid 5 cycles after channels 1..31 -> no output until channel 0 arrives; then 32 in-order words; stall_cnt ≥5 with SCHED_PERF_CNT_EN defined, 0 without.
- Backpressure: out_ready=0 for 10 cycles mid-stream -> pxl_out and ch_out hold stable; resume without loss or duplication.
- Overflow: 5 pushes to channel 3 (FIFO_DEPTH=4) with sched_en=0 -> overflow=1 after the 5th push; output stays 0; fifth word is dropped.
- Frame: PIX_PER_FRAME=4, 4 pixel pulses -> frame_done pulses exactly once, after the 128th accepted word; pix_cnt wraps; the next frame starts at ch_out=0.
- Reset asserted with 3 words buffered -> all outputs 0 asynchronously; after release, the first output corresponds to the first post-reset push.
